fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output reorder stage that sits directly downstream of the radix-2 DIF FFT core.
- The FFT core emits each N = 2^POW point frame in bit-reversed order. This block writes each frame into a ping-pong buffer at bit-reversed addresses and reads it back in natural order 0..N-1.
- The output is a valid/ready stream with start-of-packet and end-of-packet markers, intended for magnitude, peak-search or DMA consumers.

Parameters:
- DATA_WIDTH, 16, width of the real and imaginary sample words.
- POW, 4, log2 of FFT length; N = 2^POW points per frame.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  one FFT output sample (bit-reversed order) per cycle while high.
- sink_r  in  DATA_WIDTH  real part of the input sample.
- sink_i  in  DATA_WIDTH  imaginary part of the input sample.
- ready_in  in  1  downstream can accept an output sample this cycle.
- valid_out  out  1  source_r, source_i, sop and eop are valid.
- source_r  out  DATA_WIDTH  real part, natural order.
- source_i  out  DATA_WIDTH  imaginary part, natural order.
- sop  out  1  high with natural index 0 of a frame.
- eop  out  1  high with natural index N-1 of a frame.
- overflow  out  1  one-cycle pulse when an input sample is discarded.

Behaviour:
- Reset (synchronous, active-high, one clk edge): all outputs 0; write counter 0; both banks EMPTY; write bank 0; read side IDLE. A reset mid-frame discards all partial and buffered data. Memory contents are don't-care.
- Write side:
  - Write counter wcnt is POW bits and advances on every valid_in cycle, wrapping N-1 -> 0.
  - Sample is written to the current write bank at address bitrev(wcnt).
  - The frame boundary is fixed by valid_in count only; gaps in valid_in are allowed and hold wcnt.
  - The first valid_in after reset is input position 0.
- Bank states: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
  - On the write of wcnt = N-1, the write bank becomes FULL.
  - On that same edge, the write bank pointer toggles if the other bank is EMPTY.
- Overflow:
  - If the other bank is not EMPTY when the next frame starts (wcnt = 0), the whole incoming frame is discarded.
  - Memory writes are suppressed for that frame, but wcnt still advances so frame alignment is preserved.
  - overflow pulses on every discarded valid_in cycle.
  - The check is repeated at each wcnt = 0.
- Read side FSM:
  - IDLE: if a FULL bank exists, go to READING with read counter rcnt = 0.
  - READING: read address is rcnt (natural order). Memory read is registered (1-cycle).
  - The output register is loaded when it is empty or is transferring (valid_out && ready_in).
  - rcnt increments each time a read is issued.
  - After issuing rcnt = N-1: the bank becomes EMPTY once its last sample is loaded into the output register. Then go to IDLE, or go directly to READING of the other bank if it is FULL, with no bubble.
- Latency: the write of input position N-1 at edge k gives valid_out high after edge k+2 with sop = 1, provided the read side is idle and ready_in = 1.
- Throughput: one sample per cycle sustained when ready_in = 1.
- Handshake:
  - While valid_out && !ready_in, source_r, source_i, sop and eop hold stable.
  - valid_out never drops without a transfer.
  - A transfer occurs on an edge with valid_out && ready_in.
  - sop = (natural index == 0); eop = (natural index == N-1).
- Simultaneous events: the last write of a bank on the same edge as the last read of the other bank is legal. The read bank goes EMPTY, and the freshly FULL bank is scheduled for the next read; no overflow.
- Arithmetic: pure data movement; no scaling or rounding. bitrev() reverses the POW address bits.

Decomposition:
- Shared package (fft_pkg):
  - DATA_WIDTH and POW defaults.
  - typedef cplx_t (packed re/im, DATA_WIDTH each).
  - typedef bank_state_t enum {EMPTY, FILLING, FULL, READING}.
  - function bitrev (POW-bit).
- One sub-module: fft_pingpong_ram, simple dual-port RAM of 2*N x 2*DATA_WIDTH with a registered read port. Bank select is the address MSB.

Test Plan:
- Reset then 16 valid inputs with sink_r = 0..15, sink_i = 0, ready_in = 1 -> output sink_r order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; sop on first, eop on last; first valid_out 2 cycles after the 16th input.
- 3 back-to-back frames with ready_in = 1 -> 48 contiguous outputs, no overflow, no bubble between frames.
- ready_in held low for 20 cycles mid-frame -> outputs frozen, no sample lost or duplicated. A further 2 frames in -> the 3rd frame is discarded; overflow pulses 16 times; output shows frames 1 and 2 only.
- valid_in toggling every other cycle (frame values 100..115) -> same bit-reversal mapping, correct sop/eop.
- rst asserted at input position 7 of a frame, then a clean frame -> no output from the partial frame; the clean frame reorders correctly starting at position 0.
- Random ready_in (50%) over 10 frames with a scoreboard -> exact natural-order match, valid_out/data stable while stalled.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder stage.
package fft_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_POW        = 4;

  // One complex sample. The real part sits in the upper half of the word.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] re;
    logic [DEFAULT_DATA_WIDTH-1:0] im;
  } cplx_t;

  // Lifecycle of one ping-pong bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  // Reverses the low 'width' bits of 'value'. All higher result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int b = 0; b < width; b++) begin
      result[5'(b)] = value[5'(width - 1 - b)];
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port RAM that holds both ping-pong banks.
// The bank is selected by the address MSB. The read port is registered, and that
// register also serves as the output data register of the reorder stage.
module fft_pingpong_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [1 << AW];

  // Write port.
  // NOTE: the storage array is deliberately left unreset. Its contents are never
  // observed before being written, and a reset on the array would prevent block-RAM
  // inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port. It holds its value while re is low, which keeps a stalled
  // output stable.
  // NOTE: registers use non-blocking assignments so that every flop samples
  // pre-edge values, independent of the order in which the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order through a ping-pong buffer.
// Output is a valid/ready stream with sop/eop frame markers.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int POW        = DEFAULT_POW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] sink_r,
  input  logic [DATA_WIDTH-1:0] sink_i,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] source_r,
  output logic [DATA_WIDTH-1:0] source_i,
  output logic                  sop,
  output logic                  eop,
  output logic                  overflow
);

  localparam logic [POW-1:0] LAST = '1;   // index N-1

  localparam logic [0:0] RD_IDLE    = 1'b0;
  localparam logic [0:0] RD_READING = 1'b1;

  // Write side
  logic [POW-1:0] wcnt;
  logic           wbank;       // bank that the current or next frame targets
  logic           accepting;   // the frame in progress is being stored

  // Bank bookkeeping
  bank_state_t    bank_state [2];

  // Read side
  logic [0:0]     rd_state;
  logic           rbank;
  logic [POW-1:0] rcnt;

  // Combinational decisions
  logic           load;        // issue a RAM read, which loads the output register
  logic           last_load;   // that read is the final sample of the bank
  logic [1:0]     bank_free;   // bank is EMPTY, or is released on this edge
  logic           frame_start;
  logic           accept;
  logic           tgt_bank;
  logic           we;
  logic [POW:0]   waddr;
  logic           pick_valid;
  logic           pick;
  logic [2*DATA_WIDTH-1:0] rd_data;

  // Decisions for this cycle. A bank whose last sample is being read on this edge
  // already counts as free, so back-to-back frames never see a false overflow.
  // NOTE: every signal gets a default at the top of the block. This prevents a
  // path that leaves a value unassigned, which would infer a latch.
  always_comb begin
    load         = (rd_state == RD_READING) && (!valid_out || ready_in);
    last_load    = load && (rcnt == LAST);
    bank_free[0] = (bank_state[0] == EMPTY) || (last_load && !rbank);
    bank_free[1] = (bank_state[1] == EMPTY) || (last_load && rbank);
    frame_start  = valid_in && (wcnt == '0);
    tgt_bank     = wbank;
    accept       = accepting;
    if (frame_start) begin
      if (bank_free[wbank]) begin
        accept = 1'b1;
      end else if (bank_free[~wbank]) begin
        tgt_bank = ~wbank;
        accept   = 1'b1;
      end else begin
        accept = 1'b0;
      end
    end
    we         = valid_in && accept;
    waddr      = {tgt_bank, POW'(bitrev(32'(wcnt), POW))};
    pick_valid = (bank_state[0] == FULL) || (bank_state[1] == FULL);
    pick       = (bank_state[~rbank] == FULL) ? ~rbank : rbank;
  end

  // Write counter, write-bank pointer, frame-accept flag and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      accepting <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= valid_in && !accept;
      if (valid_in) begin
        wcnt      <= wcnt + POW'(1);
        accepting <= accept;
        if (accept && (wcnt == LAST)) begin
          wbank <= bank_free[~tgt_bank] ? ~tgt_bank : tgt_bank;
        end else if (frame_start) begin
          wbank <= tgt_bank;
        end
      end
    end
  end

  // Bank state machine. Read-side updates come first. A write-side update on the same
  // edge takes precedence, so a bank that is released and refilled on one edge ends
  // up FILLING.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
    end else begin
      if ((rd_state == RD_IDLE) && pick_valid) begin
        bank_state[pick] <= READING;
      end
      if (last_load) begin
        bank_state[rbank] <= EMPTY;
        if (bank_state[~rbank] == FULL) begin
          bank_state[~rbank] <= READING;
        end
      end
      if (we && (wcnt == LAST)) begin
        bank_state[tgt_bank] <= FULL;
      end else if (we && frame_start) begin
        bank_state[tgt_bank] <= FILLING;
      end
    end
  end

  // Read FSM: walks a FULL bank in natural order. After the last read it chains
  // straight into the other bank when that bank is already FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rbank    <= 1'b0;
      rcnt     <= '0;
    end else if (rd_state == RD_IDLE) begin
      if (pick_valid) begin
        rd_state <= RD_READING;
        rbank    <= pick;
        rcnt     <= '0;
      end
    end else if (load) begin
      rcnt <= rcnt + POW'(1);
      if (rcnt == LAST) begin
        if (bank_state[~rbank] == FULL) begin
          rbank <= ~rbank;
        end else begin
          rd_state <= RD_IDLE;
        end
      end
    end
  end

  // Output valid and frame markers, updated in step with the RAM read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
    end else if (load) begin
      valid_out <= 1'b1;
      sop       <= (rcnt == '0);
      eop       <= (rcnt == LAST);
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

  fft_pingpong_ram #(
    .WIDTH (2 * DATA_WIDTH),
    .AW    (POW + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata ({sink_r, sink_i}),
    .re    (load),
    .raddr ({rbank, rcnt}),
    .rdata (rd_data)
  );

  assign source_r = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign source_i = rd_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed testbench for fft_bitrev_reorder (N = 16).
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] sink_r;
  logic [15:0] sink_i;
  logic        ready_in;
  logic        valid_out;
  logic [15:0] source_r;
  logic [15:0] source_i;
  logic        sop;
  logic        eop;
  logic        overflow;

  typedef struct {
    cplx_t d;
    logic  sop;
    logic  eop;
    int    cyc;
  } rec_t;

  typedef struct {
    logic [15:0] in_r;
    logic [15:0] exp_r;
    logic        exp_sop;
    logic        exp_eop;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ovf_cnt  = 0;
  int   cyc      = 0;
  rec_t out_q[$];
  rec_t exp_q[$];
  logic stalled  = 1'b0;
  rec_t held;
  bit   rnd_on   = 1'b0;

  int   order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  vec_t tbl [16];

  fft_bitrev_reorder #(.DATA_WIDTH(16), .POW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sink_r    (sink_r),
    .sink_i    (sink_i),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .source_r  (source_r),
    .source_i  (source_i),
    .sop       (sop),
    .eop       (eop),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int rev4(input int v);
    logic [3:0] a;
    a = 4'(v);
    return int'({a[0], a[1], a[2], a[3]});
  endfunction

  function automatic logic [15:0] im_of(input int v);
    return 16'(v * 5) ^ 16'h5A5A;
  endfunction

  // Output monitor: records transfers, counts overflow pulses, and checks that a
  // stalled output holds its value.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall hold", 64'({valid_out, source_r, source_i, sop, eop}),
              64'({1'b1, held.d, held.sop, held.eop}));
      end
      if (valid_out && ready_in) begin
        rec_t r;
        r.d   = {source_r, source_i};
        r.sop = sop;
        r.eop = eop;
        r.cyc = cyc;
        out_q.push_back(r);
      end
      if (overflow) ovf_cnt++;
      stalled  = valid_out && !ready_in;
      held.d   = {source_r, source_i};
      held.sop = sop;
      held.eop = eop;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_q.delete();
    exp_q.delete();
    ovf_cnt = 0;
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gapped);
    for (int p = 0; p < N; p++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      sink_r   = 16'(base + p);
      sink_i   = im_of(base + p);
      if (gapped) drive_idle();
    end
  endtask

  task automatic expect_frame(input int base);
    for (int n = 0; n < N; n++) begin
      rec_t r;
      int   v;
      v     = base + rev4(n);
      r.d   = {16'(v), im_of(v)};
      r.sop = (n == 0);
      r.eop = (n == N - 1);
      r.cyc = 0;
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic compare_streams(input string tag);
    check($sformatf("%s count", tag), 64'(out_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < out_q.size(); j++) begin
      check($sformatf("%s sample %0d", tag, j),
            64'({out_q[j].d, out_q[j].sop, out_q[j].eop}),
            64'({exp_q[j].d, exp_q[j].sop, exp_q[j].eop}));
    end
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    sink_r   = '0;
    sink_i   = '0;
    for (int i = 0; i < N; i++) begin
      tbl[i].in_r    = 16'(i);
      tbl[i].exp_r   = 16'(order[i]);
      tbl[i].exp_sop = (i == 0);
      tbl[i].exp_eop = (i == N - 1);
    end

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset flags", 64'({valid_out, sop, eop, overflow}), 64'(0));
    check("reset data", 64'({source_r, source_i}), 64'(0));

    // Test 1: single frame 0..15, table-driven, plus latency
    ready_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      sink_r   = tbl[i].in_r;
      sink_i   = 16'h0;
    end
    drive_idle();
    @(negedge clk);
    check("latency edge k", 64'(valid_out), 64'(0));
    @(negedge clk);
    check("latency edge k+1", 64'(valid_out), 64'(0));
    @(negedge clk);
    check("latency edge k+2", 64'({valid_out, sop}), 64'(2'b11));
    wait_outputs(N, 200);
    check("t1 count", 64'(out_q.size()), 64'(N));
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      check($sformatf("t1 vec %0d", i),
            64'({out_q[i].d.re, out_q[i].d.im, out_q[i].sop, out_q[i].eop}),
            64'({tbl[i].exp_r, 16'h0, tbl[i].exp_sop, tbl[i].exp_eop}));
    end

    // Test 2: three back-to-back frames
    do_reset();
    ready_in = 1'b1;
    send_frame(16'h100, 1'b0);
    send_frame(16'h200, 1'b0);
    send_frame(16'h300, 1'b0);
    drive_idle();
    expect_frame(16'h100);
    expect_frame(16'h200);
    expect_frame(16'h300);
    wait_outputs(3 * N, 400);
    compare_streams("t2");
    check("t2 overflow", 64'(ovf_cnt), 64'(0));
    for (int j = 1; j < out_q.size(); j++) begin
      check($sformatf("t2 no bubble %0d", j), 64'(out_q[j].cyc - out_q[j-1].cyc), 64'(1));
    end

    // Test 3: 20-cycle stall mid-frame while three frames arrive; the third frame is dropped
    do_reset();
    ready_in = 1'b1;
    fork
      begin
        send_frame(16'h300, 1'b0);
        send_frame(16'h400, 1'b0);
        send_frame(16'h500, 1'b0);
        drive_idle();
      end
      begin
        repeat (20) @(posedge clk);
        #1 ready_in = 1'b0;
        repeat (20) @(posedge clk);
        #1 ready_in = 1'b1;
      end
    join
    expect_frame(16'h300);
    expect_frame(16'h400);
    wait_outputs(2 * N, 400);
    compare_streams("t3");
    check("t3 overflow pulses", 64'(ovf_cnt), 64'(16));

    // Test 4: valid_in toggling every other cycle
    do_reset();
    ready_in = 1'b1;
    send_frame(100, 1'b1);
    expect_frame(100);
    wait_outputs(N, 400);
    compare_streams("t4");

    // Test 5: reset at input position 7, then a clean frame
    do_reset();
    ready_in = 1'b1;
    for (int p = 0; p < 7; p++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      sink_r   = 16'(900 + p);
      sink_i   = im_of(900 + p);
    end
    @(posedge clk); #1;
    rst      = 1'b1;
    sink_r   = 16'(907);
    @(posedge clk); #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    repeat (20) @(negedge clk);
    check("t5 no partial output", 64'(out_q.size()), 64'(0));
    send_frame(16'h600, 1'b0);
    drive_idle();
    expect_frame(16'h600);
    wait_outputs(N, 400);
    compare_streams("t5");
    check("t5 overflow", 64'(ovf_cnt), 64'(0));

    // Test 6: random ready over 10 frames
    do_reset();
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          ready_in = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int f = 0; f < 10; f++) begin
          int k;
          k = 0;
          while (f >= 2 && out_q.size() < N * (f - 1) && k < 1000) begin
            @(negedge clk);
            k++;
          end
          send_frame(16'h1000 + f * N, 1'b0);
          drive_idle();
          expect_frame(16'h1000 + f * N);
        end
        wait_outputs(10 * N, 3000);
        rnd_on = 1'b0;
      end
    join
    ready_in = 1'b1;
    compare_streams("t6");
    check("t6 overflow", 64'(ovf_cnt), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
